// File: rtl/safety_arm_ctrl_if.sv
// Bundle between the host register file / limit checker and the arming
// sequencer. The host side drives requests and config; the sequencer drives
// laser permission, the clear strobe and the diagnostics.
interface safety_arm_ctrl_if;
  logic        arm_req;
  logic        disarm_req;
  logic        clear_req;
  logic [3:0]  fail_in;
  logic [3:0]  fault_mask;
  logic [15:0] arm_delay;
  logic        laser_enable;
  logic        clear_fail;
  logic [2:0]  state;
  logic [3:0]  first_fault;
  logic [3:0]  fault_latched;
  logic [7:0]  fault_count;

  modport master (
    output arm_req, disarm_req, clear_req, fail_in, fault_mask, arm_delay,
    input  laser_enable, clear_fail, state, first_fault, fault_latched, fault_count
  );

  modport slave (
    input  arm_req, disarm_req, clear_req, fail_in, fault_mask, arm_delay,
    output laser_enable, clear_fail, state, first_fault, fault_latched, fault_count
  );
endinterface

// File: rtl/safety_arm_ctrl.sv
// Laser arming sequencer: qualifies a fault-free delay before granting
// laser_enable, drops it one cycle after any unmasked fail flag, latches
// fault diagnostics and runs a timed clear-and-recheck of the checker.
module safety_arm_ctrl #(
  parameter int CLEAR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rstn,
  safety_arm_ctrl_if.slave  bus
);

  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMING   = 3'd1,
    ARMED    = 3'd2,
    FAULT    = 3'd3,
    CLEARING = 3'd4
  } state_t;

  state_t        state_q;
  logic [15:0]   arm_cnt_q;
  logic [CW-1:0] clr_cnt_q;
  logic          laser_enable_q;
  logic          clear_fail_q;
  logic [3:0]    first_fault_q;
  logic [3:0]    fault_latched_q;
  logic [7:0]    fault_count_q;

  logic [3:0]    act_d;
  logic          any_d;
  logic          enter_fault_d;
  logic [15:0]   arm_last_d;
  logic [7:0]    fault_count_d;

  // Masked fail flags and the decision whether this edge is a FAULT entry.
  // During the clear strobe the checker flags are expected to be sticky, so
  // only the recheck cycle of CLEARING may re-enter FAULT.
  always_comb begin
    act_d         = bus.fail_in & ~bus.fault_mask;
    any_d         = |act_d;
    arm_last_d    = (bus.arm_delay == 16'd0) ? 16'd0 : bus.arm_delay - 16'd1;
    fault_count_d = (fault_count_q == 8'hFF) ? 8'hFF : fault_count_q + 8'd1;
    enter_fault_d = 1'b0;
    case (state_q)
      IDLE, ARMING, ARMED: enter_fault_d = any_d;
      CLEARING:            enter_fault_d = any_d && !clear_fail_q;
      default:             enter_fault_d = 1'b0;
    endcase
  end

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= IDLE;
      arm_cnt_q       <= '0;
      clr_cnt_q       <= '0;
      laser_enable_q  <= 1'b0;
      clear_fail_q    <= 1'b0;
      first_fault_q   <= '0;
      fault_latched_q <= '0;
      fault_count_q   <= '0;
    end else begin
      // Sticky diagnostics accumulate except while the clear strobe is out.
      if (!clear_fail_q) begin
        fault_latched_q <= fault_latched_q | act_d;
      end

      if (enter_fault_d) begin
        state_q        <= FAULT;
        laser_enable_q <= 1'b0;
        first_fault_q  <= act_d;
        fault_count_q  <= fault_count_d;
      end else begin
        case (state_q)
          IDLE: begin
            // A simultaneous disarm has nothing to undo here, so arm wins.
            if (bus.arm_req) begin
              state_q   <= ARMING;
              arm_cnt_q <= '0;
            end
          end
          ARMING: begin
            if (bus.disarm_req) begin
              state_q <= IDLE;
            end else if (arm_cnt_q >= arm_last_d) begin
              // ">=" lets a lowered delay that is already passed arm at once.
              state_q        <= ARMED;
              laser_enable_q <= 1'b1;
            end else begin
              arm_cnt_q <= arm_cnt_q + 16'd1;
            end
          end
          ARMED: begin
            if (bus.disarm_req) begin
              state_q        <= IDLE;
              laser_enable_q <= 1'b0;
            end
          end
          FAULT: begin
            if (bus.clear_req) begin
              state_q      <= CLEARING;
              clr_cnt_q    <= '0;
              clear_fail_q <= 1'b1;
            end
          end
          CLEARING: begin
            if (clear_fail_q) begin
              if (clr_cnt_q == CLR_LAST) begin
                clear_fail_q <= 1'b0;
              end else begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
              end
            end else begin
              // Recheck passed clean: back to IDLE with fresh diagnostics.
              state_q         <= IDLE;
              fault_latched_q <= '0;
            end
          end
          default: begin
            state_q        <= IDLE;
            laser_enable_q <= 1'b0;
            clear_fail_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.laser_enable  = laser_enable_q;
  assign bus.clear_fail    = clear_fail_q;
  assign bus.state         = state_q;
  assign bus.first_fault   = first_fault_q;
  assign bus.fault_latched = fault_latched_q;
  assign bus.fault_count   = fault_count_q;

endmodule

// File: tb/tb_safety_arm_ctrl.sv
// Directed bench for safety_arm_ctrl with CLEAR_CYCLES = 4.
module tb_safety_arm_ctrl;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  safety_arm_ctrl_if bus_if ();

  safety_arm_ctrl #(.CLEAR_CYCLES(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s: observed %0h expected %0h", tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse clear_req from FAULT and wait out strobe plus recheck.
  task automatic do_clear();
    bus_if.clear_req = 1'b1;
    tick();
    bus_if.clear_req = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    bus_if.arm_req    = 1'b0;
    bus_if.disarm_req = 1'b0;
    bus_if.clear_req  = 1'b0;
    bus_if.fail_in    = 4'h0;
    bus_if.fault_mask = 4'h0;
    bus_if.arm_delay  = 16'd0;
    tick();
    tick();
    chk("rst_state", bus_if.state, 0);
    chk("rst_laser", bus_if.laser_enable, 0);
    chk("rst_cf", bus_if.clear_fail, 0);
    chk("rst_ff", bus_if.first_fault, 0);
    chk("rst_fl", bus_if.fault_latched, 0);
    chk("rst_fc", bus_if.fault_count, 0);

    // Arm with delay 5: ARMING right after the request edge, laser 5 edges later.
    rstn = 1'b1;
    bus_if.arm_delay = 16'd5;
    bus_if.arm_req = 1'b1;
    tick();
    bus_if.arm_req = 1'b0;
    chk("arm_state", bus_if.state, 1);
    chk("arm_laser", bus_if.laser_enable, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arming_laser", bus_if.laser_enable, 0);
      chk("arming_cf", bus_if.clear_fail, 0);
    end
    tick();
    chk("armed_laser", bus_if.laser_enable, 1);
    chk("armed_state", bus_if.state, 2);

    // Current fault in ARMED drops the laser one cycle later.
    bus_if.fail_in = 4'b1000;
    tick();
    bus_if.fail_in = 4'h0;
    chk("f1_laser", bus_if.laser_enable, 0);
    chk("f1_state", bus_if.state, 3);
    chk("f1_ff", bus_if.first_fault, 4'b1000);
    chk("f1_fc", bus_if.fault_count, 1);
    chk("f1_fl", bus_if.fault_latched, 4'b1000);

    // arm/disarm ignored in FAULT.
    bus_if.arm_req = 1'b1;
    bus_if.disarm_req = 1'b1;
    tick();
    bus_if.arm_req = 1'b0;
    bus_if.disarm_req = 1'b0;
    chk("fault_ignore_arm", bus_if.state, 3);

    // Clean clear: 4 strobe cycles, one recheck, back to IDLE.
    bus_if.clear_req = 1'b1;
    tick();
    bus_if.clear_req = 1'b0;
    chk("clr_state", bus_if.state, 4);
    chk("clr_cf0", bus_if.clear_fail, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_cf", bus_if.clear_fail, 1);
    end
    tick();
    chk("recheck_cf", bus_if.clear_fail, 0);
    chk("recheck_state", bus_if.state, 4);
    tick();
    chk("clr_idle", bus_if.state, 0);
    chk("clr_fl", bus_if.fault_latched, 0);
    chk("clr_ff_hold", bus_if.first_fault, 4'b1000);
    chk("clr_fc_hold", bus_if.fault_count, 1);

    // Fault from IDLE, then a clear whose recheck still sees the flag.
    bus_if.fail_in = 4'b0010;
    tick();
    chk("f2_state", bus_if.state, 3);
    chk("f2_fc", bus_if.fault_count, 2);
    bus_if.clear_req = 1'b1;
    tick();
    bus_if.clear_req = 1'b0;
    bus_if.fail_in = 4'b0110;
    chk("clr2_state", bus_if.state, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr2_strobe_state", bus_if.state, 4);
    end
    tick();
    bus_if.fail_in = 4'b0010;
    chk("clr2_recheck_cf", bus_if.clear_fail, 0);
    tick();
    chk("clr2_refault", bus_if.state, 3);
    chk("clr2_fc", bus_if.fault_count, 3);
    chk("clr2_ff", bus_if.first_fault, 4'b0010);
    chk("clr2_fl", bus_if.fault_latched, 4'b0010);
    bus_if.fail_in = 4'h0;
    do_clear();
    chk("clr3_idle", bus_if.state, 0);

    // Masked flag does not block arming; unmasking it faults next cycle.
    bus_if.fault_mask = 4'b0001;
    bus_if.fail_in = 4'b0001;
    bus_if.arm_delay = 16'd3;
    bus_if.arm_req = 1'b1;
    tick();
    bus_if.arm_req = 1'b0;
    chk("mask_arming", bus_if.state, 1);
    tick();
    tick();
    chk("mask_arming2", bus_if.state, 1);
    tick();
    chk("mask_armed", bus_if.state, 2);
    chk("mask_laser", bus_if.laser_enable, 1);
    bus_if.fault_mask = 4'h0;
    tick();
    chk("unmask_state", bus_if.state, 3);
    chk("unmask_laser", bus_if.laser_enable, 0);
    chk("unmask_ff", bus_if.first_fault, 4'b0001);
    chk("unmask_fc", bus_if.fault_count, 4);
    chk("unmask_fl", bus_if.fault_latched, 4'b0001);
    bus_if.fail_in = 4'h0;
    do_clear();
    chk("unmask_clr_idle", bus_if.state, 0);

    // arm_delay 0 acts as 1; arm+disarm together in IDLE still arms.
    bus_if.arm_delay = 16'd0;
    bus_if.arm_req = 1'b1;
    bus_if.disarm_req = 1'b1;
    tick();
    bus_if.arm_req = 1'b0;
    bus_if.disarm_req = 1'b0;
    chk("d0_arming", bus_if.state, 1);
    tick();
    chk("d0_armed", bus_if.state, 2);
    chk("d0_laser", bus_if.laser_enable, 1);

    // disarm + fault in ARMED: fault wins.
    bus_if.disarm_req = 1'b1;
    bus_if.fail_in = 4'b0100;
    tick();
    bus_if.disarm_req = 1'b0;
    bus_if.fail_in = 4'h0;
    chk("dis_fault_state", bus_if.state, 3);
    chk("dis_fault_fc", bus_if.fault_count, 5);
    chk("dis_fault_ff", bus_if.first_fault, 4'b0100);

    // Reset in the middle of the clear strobe.
    bus_if.clear_req = 1'b1;
    tick();
    bus_if.clear_req = 1'b0;
    tick();
    chk("midclr_cf", bus_if.clear_fail, 1);
    rstn = 1'b0;
    tick();
    chk("midrst_state", bus_if.state, 0);
    chk("midrst_cf", bus_if.clear_fail, 0);
    chk("midrst_fc", bus_if.fault_count, 0);
    chk("midrst_ff", bus_if.first_fault, 0);
    rstn = 1'b1;

    // Lowering arm_delay below the elapsed count arms on the next edge.
    bus_if.arm_delay = 16'd10;
    bus_if.arm_req = 1'b1;
    tick();
    bus_if.arm_req = 1'b0;
    repeat (5) tick();
    chk("lower_arming", bus_if.state, 1);
    bus_if.arm_delay = 16'd2;
    tick();
    chk("lower_armed", bus_if.state, 2);

    // Disarm from ARMED and from ARMING.
    bus_if.disarm_req = 1'b1;
    tick();
    bus_if.disarm_req = 1'b0;
    chk("disarm_state", bus_if.state, 0);
    chk("disarm_laser", bus_if.laser_enable, 0);
    bus_if.arm_delay = 16'd5;
    bus_if.arm_req = 1'b1;
    tick();
    bus_if.arm_req = 1'b0;
    tick();
    bus_if.disarm_req = 1'b1;
    tick();
    bus_if.disarm_req = 1'b0;
    chk("disarm_arming", bus_if.state, 0);

    // 256 FAULT entries: counter saturates at 255.
    for (int n = 1; n <= 256; n++) begin
      bus_if.fail_in = 4'b0001;
      tick();
      bus_if.fail_in = 4'h0;
      if (n == 255) chk("sat_255", bus_if.fault_count, 255);
      do_clear();
    end
    chk("sat_256", bus_if.fault_count, 255);
    chk("sat_state", bus_if.state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
